rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Shares the register file's single write port (port 3) between two sources: the in-order writeback stage and a long-latency result source such as a multi-cycle mul/div unit.
- Writeback always has priority and is never stalled. Long-latency results use a valid/ready handshake and wait in a small in-order buffer when the port is busy.
- Keeps a pending-destination scoreboard so decode stalls on RAW/WAW hazards against outstanding long-latency ops.
- Sits between the writeback stage, the long-latency unit, decode stall logic and the register file.

Parameters:
- DATA_WIDTH, 32, register data width.
- ADDR_WIDTH, 5, register address width (2**ADDR_WIDTH registers; register 0 hardwired zero).
- BUF_DEPTH, 2, long-latency result buffer entries; power of two, >=2.
- STARVE_LIMIT, 4, consecutive blocked cycles before starvation stall (optional feature only).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- wb_we_i  in  1  writeback write enable.
- wb_wa_i  in  ADDR_WIDTH  writeback destination.
- wb_wd_i  in  DATA_WIDTH  writeback data.
- lu_valid_i  in  1  long-latency result valid.
- lu_wa_i  in  ADDR_WIDTH  long-latency destination.
- lu_wd_i  in  DATA_WIDTH  long-latency data.
- lu_ready_o  out  1  arbiter can accept a long-latency result.
- issue_i  in  1  decode issues a long-latency op this cycle.
- issue_wa_i  in  ADDR_WIDTH  destination reserved by that op.
- rs_d_i  in  ADDR_WIDTH  decode source A.
- rt_d_i  in  ADDR_WIDTH  decode source B.
- stall_d_o  out  1  decode must stall (hazard on pending register).
- we3_o  out  1  register file write enable.
- wa3_o  out  ADDR_WIDTH  register file write address.
- wd3_o  out  DATA_WIDTH  register file write data.
- pending_o  out  2**ADDR_WIDTH  scoreboard bit vector.
- buf_count_o  out  $clog2(BUF_DEPTH)+1  buffer occupancy.
- starve_stall_o  out  1  starvation stall request to the upstream pipeline.

Behaviour:
- Reset: buffer emptied, scoreboard cleared, starvation counter cleared. While rst_i is high, every output is 0: we3_o, wa3_o, wd3_o, lu_ready_o, stall_d_o, pending_o, buf_count_o, starve_stall_o.
- A write is "effective" if its enable/valid is high and its address is nonzero.
- Port priority each cycle, combinational select:
  - (1) Effective writeback: passes through with 0-cycle latency.
  - (2) Otherwise, if the buffer is non-empty: the buffer head is written and popped at the clock edge.
  - (3) Otherwise, an accepted effective lu result bypasses directly, with 0-cycle latency.
  - (4) Otherwise we3_o=0; wa3_o and wd3_o hold 0.
- lu_ready_o = (buf_count < BUF_DEPTH), from registered state only; it never depends on lu_valid_i. Accept = lu_valid_i & lu_ready_o.
- An accepted lu result not written this cycle is pushed to the buffer tail.
- Ordering: lu results reach the port strictly in acceptance order. Bypass is allowed only when the buffer is empty.
- Push and pop in the same cycle: occupancy unchanged, no overflow. Full buffer with head popped: lu_ready_o is still 0 that cycle; space reopens next cycle.
- lu result to register 0: accepted, counts toward handshake, never written, never buffered, no scoreboard change.
- Writeback to register 0: treated as idle, so the port is free for buffered or bypass traffic.
- Scoreboard:
  - issue_i with issue_wa_i != 0 sets pending[issue_wa_i] at the next edge.
  - The bit clears at the edge where an lu write to that address drives the port.
  - Same-cycle set and clear of the same bit: set wins.
  - Bit 0 is never set.
- stall_d_o = pending[rs_d_i] | pending[rt_d_i] | (issue_i & pending[issue_wa_i]), computed from the registered scoreboard. It stays asserted in the cycle the clearing write occurs and drops the following cycle.
- Decode stall prevents writeback to a pending register; the arbiter performs no check.
- Reset mid-operation: buffered results are discarded and pending bits cleared. The lu source must also be reset.

Optional Feature:
- Macro RF_ARB_STARVE_GUARD_EN.
- Defined:
  - A counter increments each cycle the buffer is non-empty and the port is taken by writeback; it resets to 0 on any cycle the buffer head is written or the buffer is empty.
  - When the count reaches STARVE_LIMIT, starve_stall_o asserts (registered) until the next buffer pop.
  - Upstream is expected to stop writeback, so starve_stall_o deasserts the cycle after the head drains.
- Undefined: starve_stall_o tied 0, no counter logic.

Test Plan:
- Bypass: empty buffer, no writeback; lu_valid_i=1, wa=5, wd=0x1234 -> same cycle we3_o=1, wa3_o=5, wd3_o=0x1234, lu_ready_o=1, buf_count_o=0.
- Conflict: writeback to r3 and lu to r7 in the same cycle -> port writes r3; next cycle, with no writeback, writes r7; buf_count_o goes 1 then 0.
- Full: writeback held busy for 4 cycles, lu offers r8, r9, r10 -> r8 and r9 accepted, lu_ready_o=0 after the second accept, r10 held. Writeback then idle -> writes in order r8, r9, r10.
- Scoreboard: issue_i with wa=12; next cycle rs_d_i=12 -> stall_d_o=1. lu result r12 written -> stall_d_o drops one cycle later; issue and clear of r12 in the same cycle -> pending[12] stays 1.
- Register zero: lu to r0 and writeback to r0 -> we3_o=0, no buffer push, pending_o unchanged, handshake completes.
- Async reset with buffer holding 2 entries and pending bits set -> immediately all outputs 0; after release, buf_count_o=0 and lu_ready_o=1.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Shares register-file write port 3 between the writeback stage and a long-latency result source.
// Optional starvation guard: define RF_ARB_STARVE_GUARD_EN.
module rf_write_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 5,
   parameter int BUF_DEPTH    = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         wb_we_i,
   input  logic [ADDR_WIDTH-1:0]        wb_wa_i,
   input  logic [DATA_WIDTH-1:0]        wb_wd_i,
   input  logic                         lu_valid_i,
   input  logic [ADDR_WIDTH-1:0]        lu_wa_i,
   input  logic [DATA_WIDTH-1:0]        lu_wd_i,
   output logic                         lu_ready_o,
   input  logic                         issue_i,
   input  logic [ADDR_WIDTH-1:0]        issue_wa_i,
   input  logic [ADDR_WIDTH-1:0]        rs_d_i,
   input  logic [ADDR_WIDTH-1:0]        rt_d_i,
   output logic                         stall_d_o,
   output logic                         we3_o,
   output logic [ADDR_WIDTH-1:0]        wa3_o,
   output logic [DATA_WIDTH-1:0]        wd3_o,
   output logic [2**ADDR_WIDTH-1:0]     pending_o,
   output logic [$clog2(BUF_DEPTH):0]   buf_count_o,
   output logic                         starve_stall_o
);
   localparam int NREG = 2**ADDR_WIDTH;
   localparam int PW   = $clog2(BUF_DEPTH);
   localparam int CW   = PW + 1;

   if (BUF_DEPTH < 2 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_param
      $error("rf_write_arbiter: BUF_DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
   end

   logic [ADDR_WIDTH-1:0] r_buf_wa [BUF_DEPTH];
   logic [DATA_WIDTH-1:0] r_buf_wd [BUF_DEPTH];
   logic [PW-1:0]         r_rd_ptr;
   logic [PW-1:0]         r_wr_ptr;
   logic [CW-1:0]         r_count;
   logic [NREG-1:0]       r_pending;

   logic                  w_buf_empty, w_lu_ready, w_wb_eff, w_lu_eff;
   logic                  w_pop, w_bypass, w_push, w_starve;
   logic                  w_we;
   logic [ADDR_WIDTH-1:0] w_wa;
   logic [DATA_WIDTH-1:0] w_wd;
   logic [NREG-1:0]       w_set, w_clr, w_pending_next;

   assign w_buf_empty = (r_count == '0);
   assign w_lu_ready  = (r_count < CW'(BUF_DEPTH));
   assign w_wb_eff    = wb_we_i & (wb_wa_i != '0);
   assign w_lu_eff    = lu_valid_i & w_lu_ready & (lu_wa_i != '0);
   // Bypass only with an empty buffer keeps lu results in acceptance order.
   assign w_pop       = ~w_wb_eff & ~w_buf_empty;
   assign w_bypass    = ~w_wb_eff & w_buf_empty & w_lu_eff;
   assign w_push      = w_lu_eff & ~w_bypass;

   always_comb begin
      w_we = 1'b0;
      w_wa = '0;
      w_wd = '0;
      if (w_wb_eff) begin
         w_we = 1'b1;
         w_wa = wb_wa_i;
         w_wd = wb_wd_i;
      end else if (w_pop) begin
         w_we = 1'b1;
         w_wa = r_buf_wa[r_rd_ptr];
         w_wd = r_buf_wd[r_rd_ptr];
      end else if (w_bypass) begin
         w_we = 1'b1;
         w_wa = lu_wa_i;
         w_wd = lu_wd_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_buf_wa[r_wr_ptr] <= lu_wa_i;
         r_buf_wd[r_wr_ptr] <= lu_wd_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Set wins over a same-cycle clear; register 0 is never pending.
   assign w_clr          = (w_pop | w_bypass) ? (NREG'(1) << w_wa) : '0;
   assign w_set          = (issue_i && issue_wa_i != '0) ? (NREG'(1) << issue_wa_i) : '0;
   assign w_pending_next = ((r_pending & ~w_clr) | w_set) & ~NREG'(1);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_pending <= '0;
      else       r_pending <= w_pending_next;
   end

`ifdef RF_ARB_STARVE_GUARD_EN
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   logic [SW-1:0] r_starve_cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                          r_starve_cnt <= '0;
      else if (w_buf_empty || w_pop)      r_starve_cnt <= '0;
      else if (r_starve_cnt < SW'(STARVE_LIMIT)) r_starve_cnt <= r_starve_cnt + SW'(1);
   end

   assign w_starve = (r_starve_cnt >= SW'(STARVE_LIMIT));
`else
   assign w_starve = 1'b0;
`endif

   // Writeback passes through combinationally, so outputs are gated to read 0 during reset.
   assign we3_o          = ~rst_i & w_we;
   assign wa3_o          = rst_i ? '0 : w_wa;
   assign wd3_o          = rst_i ? '0 : w_wd;
   assign lu_ready_o     = ~rst_i & w_lu_ready;
   assign pending_o      = rst_i ? '0 : r_pending;
   assign buf_count_o    = rst_i ? '0 : r_count;
   assign starve_stall_o = ~rst_i & w_starve;
   assign stall_d_o      = ~rst_i & (r_pending[rs_d_i] | r_pending[rt_d_i] |
                                     (issue_i & r_pending[issue_wa_i]));
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: queue of expected lu writes plus a pending-bit model.
`timescale 1ns/1ps
module tb_rf_write_arbiter;
   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 2;

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic          wb_we_i = 1'b0;
   logic [AW-1:0] wb_wa_i = '0;
   logic [DW-1:0] wb_wd_i = '0;
   logic          lu_valid_i = 1'b0;
   logic [AW-1:0] lu_wa_i = '0;
   logic [DW-1:0] lu_wd_i = '0;
   logic          lu_ready_o;
   logic          issue_i = 1'b0;
   logic [AW-1:0] issue_wa_i = '0;
   logic [AW-1:0] rs_d_i = '0;
   logic [AW-1:0] rt_d_i = '0;
   logic          stall_d_o;
   logic          we3_o;
   logic [AW-1:0] wa3_o;
   logic [DW-1:0] wd3_o;
   logic [31:0]   pending_o;
   logic [1:0]    buf_count_o;
   logic          starve_stall_o;

   always #5 clk = ~clk;

   rf_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BUF_DEPTH(DEPTH), .STARVE_LIMIT(4)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .wb_we_i(wb_we_i), .wb_wa_i(wb_wa_i), .wb_wd_i(wb_wd_i),
      .lu_valid_i(lu_valid_i), .lu_wa_i(lu_wa_i), .lu_wd_i(lu_wd_i), .lu_ready_o(lu_ready_o),
      .issue_i(issue_i), .issue_wa_i(issue_wa_i), .rs_d_i(rs_d_i), .rt_d_i(rt_d_i),
      .stall_d_o(stall_d_o), .we3_o(we3_o), .wa3_o(wa3_o), .wd3_o(wd3_o),
      .pending_o(pending_o), .buf_count_o(buf_count_o), .starve_stall_o(starve_stall_o)
   );

   int total = 0;
   int bad   = 0;
   logic [AW+DW-1:0] luq[$];
   logic [31:0]      pend = '0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_we3"}, we3_o, 0);
      check_val({tag, "_wa3"}, wa3_o, 0);
      check_val({tag, "_wd3"}, wd3_o, 0);
      check_val({tag, "_rdy"}, lu_ready_o, 0);
      check_val({tag, "_stall"}, stall_d_o, 0);
      check_val({tag, "_pend"}, pending_o, 0);
      check_val({tag, "_cnt"}, buf_count_o, 0);
      check_val({tag, "_starve"}, starve_stall_o, 0);
   endtask

   // Entered just after a rising edge; drives one cycle, checks at the falling edge, advances the model.
   task automatic cycle(input logic wbe, input logic [AW-1:0] wba, input logic [DW-1:0] wbd,
                        input logic luv, input logic [AW-1:0] lua, input logic [DW-1:0] lud,
                        input logic iss, input logic [AW-1:0] iwa,
                        input logic [AW-1:0] rs, input logic [AW-1:0] rt, output logic acc);
      logic          exp_we, exp_rdy, exp_stall, lu_port, bypass;
      logic [AW-1:0] exp_wa;
      logic [DW-1:0] exp_wd;
      int            exp_cnt;
      wb_we_i = wbe;  wb_wa_i = wba;  wb_wd_i = wbd;
      lu_valid_i = luv; lu_wa_i = lua; lu_wd_i = lud;
      issue_i = iss;  issue_wa_i = iwa; rs_d_i = rs; rt_d_i = rt;
      @(negedge clk);
      exp_cnt = luq.size();
      exp_rdy = (exp_cnt < DEPTH);
      acc     = luv & exp_rdy;
      exp_stall = pend[rs] | pend[rt] | (iss & pend[iwa]);
      exp_we = 1'b0; exp_wa = '0; exp_wd = '0; lu_port = 1'b0; bypass = 1'b0;
      if (wbe && wba != 0) begin
         exp_we = 1'b1; exp_wa = wba; exp_wd = wbd;
      end else if (exp_cnt > 0) begin
         exp_we = 1'b1; lu_port = 1'b1;
         {exp_wa, exp_wd} = luq.pop_front();
      end else if (acc && lua != 0) begin
         exp_we = 1'b1; exp_wa = lua; exp_wd = lud; lu_port = 1'b1; bypass = 1'b1;
      end
      if (acc && lua != 0 && !bypass) luq.push_back({lua, lud});
      check_val("we3", we3_o, exp_we);
      check_val("wa3", wa3_o, exp_wa);
      check_val("wd3", wd3_o, exp_wd);
      check_val("lu_ready", lu_ready_o, exp_rdy);
      check_val("buf_count", buf_count_o, exp_cnt);
      check_val("stall_d", stall_d_o, exp_stall);
      check_val("pending", pending_o, pend);
`ifndef RF_ARB_STARVE_GUARD_EN
      check_val("starve", starve_stall_o, 0);
`endif
      if (exp_we) $display("port write wa=%0d wd=%08h lu=%0d cnt=%0d", exp_wa, exp_wd, lu_port, exp_cnt);
      if (lu_port) pend[exp_wa] = 1'b0;
      if (iss && iwa != 0) pend[iwa] = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic acc;
      int   idx;
      // Reset held with busy-looking inputs: every output must read 0.
      wb_we_i = 1'b1; wb_wa_i = 5'd3; wb_wd_i = 32'hdead; lu_valid_i = 1'b1; lu_wa_i = 5'd4;
      issue_i = 1'b1; issue_wa_i = 5'd6;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("rst_init");
      rst_i = 1'b0;

      // Bypass into an empty buffer
      cycle(0, 0, 0, 1, 5, 32'h1234, 0, 0, 0, 0, acc);
      // Writeback/lu conflict, then drain
      cycle(1, 3, 32'h33, 1, 7, 32'h77, 0, 0, 0, 0, acc);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, acc);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, acc);

      // Fill: writeback busy 4 cycles while lu offers r8, r9, r10
      idx = 0;
      for (int c = 0; c < 10; c++) begin
         cycle(c < 4, 5'(1 + c), 32'(c), idx < 3, 5'(8 + idx), 32'(32'h800 + idx), 0, 0, 0, 0, acc);
         if (acc) idx++;
      end
      check_val("full_all_accepted", idx, 3);

      // Scoreboard set, stall, clear, and set-wins
      cycle(0, 0, 0, 0, 0, 0, 1, 12, 0, 0, acc);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 12, 0, acc);
      cycle(0, 0, 0, 1, 12, 32'hc0, 0, 0, 12, 0, acc);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 12, 12, acc);
      cycle(0, 0, 0, 0, 0, 0, 1, 12, 0, 0, acc);
      cycle(0, 0, 0, 1, 12, 32'hc1, 1, 12, 0, 0, acc);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 12, acc);
      cycle(0, 0, 0, 1, 12, 32'hc2, 0, 0, 0, 0, acc);
      cycle(0, 0, 0, 0, 0, 0, 1, 0, 12, 0, acc);

      // Register zero on both sources
      cycle(1, 0, 32'hff, 1, 0, 32'hee, 0, 0, 0, 0, acc);
      check_val("r0_handshake", acc, 1);

      // Async reset with two buffered entries and pending bits
      cycle(1, 1, 32'h1, 1, 20, 32'h20, 1, 20, 0, 0, acc);
      cycle(1, 2, 32'h2, 1, 21, 32'h21, 1, 21, 0, 0, acc);
      wb_we_i = 1'b1; wb_wa_i = 5'd9; wb_wd_i = 32'h99; lu_valid_i = 1'b0; issue_i = 1'b0;
      rs_d_i = 5'd20; rt_d_i = 5'd21;
      #2 rst_i = 1'b1;
      #1 check_reset_outputs("rst_mid");
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      luq.delete();
      pend = '0;
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 20, 21, acc);

      // Random traffic
      for (int c = 0; c < 300; c++) begin
         cycle($urandom_range(0, 9) < 4, 5'($urandom), $urandom,
               $urandom_range(0, 1) == 1, 5'($urandom), $urandom,
               $urandom_range(0, 3) == 0, 5'($urandom), 5'($urandom), 5'($urandom), acc);
      end
      repeat (4) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, acc);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
